// File: rtl/rr_fifo_reader_pkg.sv
// Shared constants and width helper for the BPC sample-FIFO reader.
package bpc_fifo_pkg;
  localparam int DEF_NUM_CH = 10;
  localparam int DEF_DATA_W = 8;

  // Channel index width; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_fifo_reader_if.sv
// FIFO-side and stream-side signals of the round-robin reader; master = reader.
interface rr_fifo_reader_if
  import bpc_fifo_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH_W   = ch_w(NUM_CH)
);
  logic [NUM_CH-1:0]        rdempty;
  logic [NUM_CH*DATA_W-1:0] fifo_dout;
  logic                     stop_rd;
  logic                     halt_to_fifo;
  logic [NUM_CH-1:0]        rd_en;
  logic [DATA_W-1:0]        dout;
  logic                     dout_vld;
  logic [CH_W-1:0]          dout_ch;
  logic                     start_aga;

  modport master (
    input  rdempty, fifo_dout, stop_rd, halt_to_fifo,
    output rd_en, dout, dout_vld, dout_ch, start_aga
  );

  modport slave (
    output rdempty, fifo_dout, stop_rd, halt_to_fifo,
    input  rd_en, dout, dout_vld, dout_ch, start_aga
  );
endinterface

// File: rtl/rr_fifo_reader_arbiter.sv
// Rotating priority arbiter: first requester at or after ptr (mode=1), or ptr only (mode=0).
// Purely combinational; no state, no backpressure.
module rr_arbiter
  import bpc_fifo_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any
);
  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic                found;
  int                  off;
  int                  sum;

  // Rotating the doubled vector puts channel ptr at bit 0.
  assign dbl = {req, req};
  assign rot = dbl[ptr +: NUM_CH];

  always_comb begin
    found = 1'b0;
    off   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rot[i] && (mode || i == 0)) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    any     = found;
    gnt_idx = CH_W'(sum);
    gnt     = '0;
    if (found) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/rr_fifo_reader.sv
// Round-robin drain of NUM_CH FIFOs into one tagged stream; 1-cycle rd_en-to-dout latency.
// stop_rd blocks new reads combinationally; a word already in flight still emerges.
module rr_fifo_reader
  import bpc_fifo_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input logic        clk_rd,
  input logic        rst,
  input logic        rst_syn,
  rr_fifo_reader_if.master bus
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   ptr_nxt;
  logic [CH_W-1:0]   gnt_q;
  logic [CH_W-1:0]   gnt_idx;
  logic [NUM_CH-1:0] gnt;
  logic              any;
  logic              issue;
  logic              vld_q;
  logic              aga_q;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (~bus.rdempty),
    .ptr     (ptr),
    .mode    (SKIP_EMPTY),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign issue   = rst & ~rst_syn & ~bus.stop_rd & any;
  assign ptr_nxt = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk_rd or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      gnt_q <= '0;
      vld_q <= 1'b0;
      aga_q <= 1'b0;
    end else if (rst_syn) begin
      ptr   <= '0;
      gnt_q <= '0;
      vld_q <= 1'b0;
      aga_q <= 1'b0;
    end else begin
      vld_q <= issue;
      aga_q <= (&bus.rdempty) & bus.halt_to_fifo;
      if (issue) begin
        ptr   <= ptr_nxt;
        gnt_q <= gnt_idx;
      end
    end
  end

  // A synchronous clear also flushes the word in flight from the output.
  assign bus.rd_en     = issue ? gnt : '0;
  assign bus.dout_vld  = vld_q & ~rst_syn;
  assign bus.dout_ch   = rst_syn ? '0 : gnt_q;
  assign bus.dout      = bus.dout_vld ? bus.fifo_dout[int'(gnt_q)*DATA_W +: DATA_W] : '0;
  assign bus.start_aga = aga_q;
endmodule

// File: tb/tb_rr_fifo_reader.sv
// Directed cycle tables for skip-empty (A) and strict-order (B) readers, plus reset sequences.
module tb_rr_fifo_reader;
  typedef struct {
    logic [9:0] rdempty;
    logic       stop;
    logic       halt;
    logic       rsyn;
    logic [9:0] rd_en;
    logic       vld;
    logic [3:0] ch;
    logic       aga;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rsyn_a, rsyn_b;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t ta[$];
  vec_t tq[$];

  always #5 clk = ~clk;

  rr_fifo_reader_if #(.NUM_CH(10), .DATA_W(8)) bus_a ();
  rr_fifo_reader_if #(.NUM_CH(10), .DATA_W(8)) bus_b ();

  rr_fifo_reader #(.NUM_CH(10), .DATA_W(8), .SKIP_EMPTY(1'b1)) u_a (
    .clk_rd (clk), .rst (rst), .rst_syn (rsyn_a), .bus (bus_a.master)
  );
  rr_fifo_reader #(.NUM_CH(10), .DATA_W(8), .SKIP_EMPTY(1'b0)) u_b (
    .clk_rd (clk), .rst (rst), .rst_syn (rsyn_b), .bus (bus_b.master)
  );

  function automatic vec_t mk(input logic [9:0] re, input logic st, input logic ha,
                              input logic rs, input logic [9:0] rd, input logic vl,
                              input logic [3:0] ch, input logic ag);
    vec_t v;
    v.rdempty = re; v.stop = st; v.halt = ha; v.rsyn = rs;
    v.rd_en = rd; v.vld = vl; v.ch = ch; v.aga = ag;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input bit sel_b, input vec_t v);
    if (sel_b) begin
      bus_b.rdempty = v.rdempty; bus_b.stop_rd = v.stop; bus_b.halt_to_fifo = v.halt; rsyn_b = v.rsyn;
    end else begin
      bus_a.rdempty = v.rdempty; bus_a.stop_rd = v.stop; bus_a.halt_to_fifo = v.halt; rsyn_a = v.rsyn;
    end
  endtask

  task automatic check(input bit sel_b, input vec_t v, input int row);
    logic [9:0] rd;
    logic       vl;
    logic [3:0] ch;
    logic [7:0] d;
    logic       ag;
    logic [7:0] ed;
    if (sel_b) begin
      rd = bus_b.rd_en; vl = bus_b.dout_vld; ch = bus_b.dout_ch; d = bus_b.dout; ag = bus_b.start_aga;
    end else begin
      rd = bus_a.rd_en; vl = bus_a.dout_vld; ch = bus_a.dout_ch; d = bus_a.dout; ag = bus_a.start_aga;
    end
    ed = v.vld ? (8'hA0 + {4'h0, v.ch}) : 8'h00;
    chk(sel_b ? "B.rd_en" : "A.rd_en", row, 32'(rd), 32'(v.rd_en));
    chk(sel_b ? "B.dout_vld" : "A.dout_vld", row, 32'(vl), 32'(v.vld));
    chk(sel_b ? "B.dout_ch" : "A.dout_ch", row, 32'(ch), 32'(v.ch));
    chk(sel_b ? "B.dout" : "A.dout", row, 32'(d), 32'(ed));
    chk(sel_b ? "B.start_aga" : "A.start_aga", row, 32'(ag), 32'(v.aga));
  endtask

  initial begin
    int gseq[8];
    int prv;
    gseq = '{1, 4, 5, 6, 8, 9, 0, 1};

    // A: full rotation, all channels non-empty
    for (int k = 0; k <= 10; k++)
      ta.push_back(mk(10'h000, 0, 0, 0, 10'(1 << (k % 10)), k > 0, (k > 0) ? 4'(k - 1) : 4'h0, 0));
    // A: channels 2,3,7 empty starting from ptr=1
    for (int k = 0; k < 8; k++) begin
      prv = (k == 0) ? 0 : gseq[k-1];
      ta.push_back(mk(10'h08C, 0, 0, 0, 10'(1 << gseq[k]), 1, 4'(prv), 0));
    end
    // A: 3-cycle stall, resume at ch2
    ta.push_back(mk(10'h000, 1, 0, 0, 10'h000, 1, 4'd1, 0));
    ta.push_back(mk(10'h000, 1, 0, 0, 10'h000, 0, 4'd1, 0));
    ta.push_back(mk(10'h000, 1, 0, 0, 10'h000, 0, 4'd1, 0));
    ta.push_back(mk(10'h000, 0, 0, 0, 10'h004, 0, 4'd1, 0));
    ta.push_back(mk(10'h000, 0, 0, 0, 10'h008, 1, 4'd2, 0));
    // A: all empty with halt, then halt dropped
    ta.push_back(mk(10'h3FF, 0, 1, 0, 10'h000, 1, 4'd3, 0));
    ta.push_back(mk(10'h3FF, 0, 1, 0, 10'h000, 0, 4'd3, 1));
    ta.push_back(mk(10'h3FF, 0, 0, 0, 10'h000, 0, 4'd3, 1));
    ta.push_back(mk(10'h3FF, 0, 0, 0, 10'h000, 0, 4'd3, 0));
    // A: stream to ptr=6, then synchronous clear
    ta.push_back(mk(10'h000, 0, 0, 0, 10'h010, 0, 4'd3, 0));
    ta.push_back(mk(10'h000, 0, 0, 0, 10'h020, 1, 4'd4, 0));
    ta.push_back(mk(10'h000, 0, 0, 1, 10'h000, 0, 4'd0, 0));
    ta.push_back(mk(10'h000, 0, 0, 0, 10'h001, 0, 4'd0, 0));
    ta.push_back(mk(10'h000, 0, 0, 0, 10'h002, 1, 4'd0, 0));

    // B: strict order, ch3 empty for 5 cycles, ch4 empties right after its read
    tq.push_back(mk(10'h000, 0, 0, 0, 10'h001, 0, 4'd0, 0));
    tq.push_back(mk(10'h000, 0, 0, 0, 10'h002, 1, 4'd0, 0));
    tq.push_back(mk(10'h000, 0, 0, 0, 10'h004, 1, 4'd1, 0));
    tq.push_back(mk(10'h008, 0, 0, 0, 10'h000, 1, 4'd2, 0));
    for (int k = 0; k < 4; k++)
      tq.push_back(mk(10'h008, 0, 0, 0, 10'h000, 0, 4'd2, 0));
    tq.push_back(mk(10'h000, 0, 0, 0, 10'h008, 0, 4'd2, 0));
    tq.push_back(mk(10'h000, 0, 0, 0, 10'h010, 1, 4'd3, 0));
    tq.push_back(mk(10'h010, 0, 0, 0, 10'h020, 1, 4'd4, 0));
    tq.push_back(mk(10'h000, 0, 0, 0, 10'h040, 1, 4'd5, 0));

    for (int k = 0; k < 10; k++) begin
      bus_a.fifo_dout[k*8 +: 8] = 8'hA0 + 8'(k);
      bus_b.fifo_dout[k*8 +: 8] = 8'hA0 + 8'(k);
    end
    rst = 1'b0;
    drive(0, mk(10'h000, 0, 0, 0, 10'h000, 0, 4'd0, 0));
    drive(1, mk(10'h3FF, 0, 0, 1, 10'h000, 0, 4'd0, 0));
    #1;
    check(0, mk(10'h000, 0, 0, 0, 10'h000, 0, 4'd0, 0), -1);
    bus_a.rdempty = 10'h3FF;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (ta[r]) begin
      @(negedge clk);
      drive(0, ta[r]);
      #1;
      check(0, ta[r], r);
    end

    // Asynchronous reset mid-stream clears outputs without a clock edge
    @(negedge clk);
    drive(0, mk(10'h000, 0, 0, 0, 10'h000, 0, 4'd0, 0));
    #1;
    chk("A.pre_arst_vld", 0, 32'(bus_a.dout_vld), 32'd1);
    rst = 1'b0;
    #1;
    check(0, mk(10'h000, 0, 0, 0, 10'h000, 0, 4'd0, 0), 100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check(0, mk(10'h000, 0, 0, 0, 10'h001, 0, 4'd0, 0), 101);
    rsyn_a = 1'b1;

    foreach (tq[r]) begin
      @(negedge clk);
      drive(1, tq[r]);
      #1;
      check(1, tq[r], r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rr_fifo_reader.md
# rr_fifo_reader

Parametrised round-robin reader that drains NUM_CH parallel sample FIFOs into a single DATA_W stream for the BPC/MQ datapath. It issues one-hot read strobes in rotating order and, optionally, skips empty channels instead of waiting on them. It tags each output word with its source channel and raises `start_aga` toward `bpc_read_control` once every FIFO is drained under halt.

## Interface
- `NUM_CH`, 10, number of FIFO channels (≥2)
- `DATA_W`, 8, FIFO word width
- `SKIP_EMPTY`, 1, 1 = skip empty channels; 0 = strict order, wait on empty channel
- `clk_rd` input 1 read-side clock
- `rst` input 1 asynchronous, active-low reset
- `rst_syn` input 1 synchronous clear, same effect as `rst`
- `rdempty` input NUM_CH per-FIFO empty flags
- `fifo_dout` input NUM_CH*DATA_W FIFO read data, channel k at bits [k*DATA_W +: DATA_W]
- `stop_rd` input 1 downstream stall; no reads issued while high
- `halt_to_fifo` input 1 upstream producer finished
- `rd_en` output NUM_CH one-hot FIFO read strobe, combinational
- `dout` output DATA_W selected word
- `dout_vld` output 1 `dout` valid
- `dout_ch` output CH_W source channel index of `dout`
- `start_aga` output 1 registered restart request

## Operation
- State: pointer `ptr` (CH_W bits, range 0..NUM_CH-1), registered grant index `gnt_q`, `dout_vld` register, `start_aga` register.
- Issue condition: `stop_rd`=0, `rst_syn`=0, and the selected channel is non-empty. Otherwise `rd_en`=0.
- SKIP_EMPTY=1: selected channel = first non-empty channel searching `ptr`, `ptr`+1, …, wrapping modulo NUM_CH. On issue, `ptr` <= selected+1, wrapping NUM_CH-1 → 0.
- SKIP_EMPTY=0: selected channel = `ptr` only. Issue only if `rdempty[ptr]`=0. `ptr` advances by 1 (with wrap) only on issue; otherwise it holds.
- `rd_en` has at most one bit set. It never asserts on a channel whose `rdempty` is high in the same cycle.
- Output mux: when `dout_vld`=1, `dout` = slice `gnt_q` of `fifo_dout`; otherwise `dout`=0.
- `start_aga` <= 1 iff all `rdempty` bits are 1 and `halt_to_fifo`=1. Otherwise it is 0.
- Reset (`rst` low or `rst_syn` high): `ptr`=0, `gnt_q`=0, `dout_vld`=0, `start_aga`=0. While reset is active, `rd_en`=0, `dout`=0, and `dout_ch`=0.
- Reset mid-stream: any read issued in the same cycle as `rst_syn` is suppressed. No `dout_vld` is produced after the clear.

## Timing
- FIFO read latency is 1 cycle: `rd_en` at cycle T gives `dout_vld`=1, `dout`, and `dout_ch`=granted index at T+1.
- `dout_vld` <= (issue this cycle). `gnt_q` and `dout_ch` load only on issue.
- Back-to-back issue is allowed every cycle, giving a sustained throughput of 1 word/cycle.
- `stop_rd` rising at T: no `rd_en` at T. A word issued at T-1 still appears at T, and `ptr` holds.
- `stop_rd` falling: issue resumes in the same cycle from the held `ptr`.
- All FIFOs empty: no issue and `dout_vld` falls the next cycle. `start_aga` follows one cycle after the all-empty & halt condition.
- Simultaneous events: a channel going empty in the cycle after its read has no effect on the word in flight.

## Structure
- Package `bpc_fifo_pkg`: constant function for CH_W = max(1, $clog2(NUM_CH)), and the default NUM_CH/DATA_W values.
- Sub-module `rr_arbiter`. Parameters: NUM_CH. Inputs: `req` (= ~rdempty), `ptr`, `mode`. Outputs: one-hot `gnt`, `gnt_idx`, `any`. Implementation: double-width rotate-and-priority-encode.
- The top level holds the pointer, the registers, and the output mux.

## Test plan
- NUM_CH=10, SKIP_EMPTY=1, all non-empty, `stop_rd`=0 → `rd_en` cycles 0x001, 0x002 … 0x200, 0x001. `dout_ch` follows 0..9 one cycle later, and `dout` equals the matching `fifo_dout` slice.
- SKIP_EMPTY=1, channels 2,3,7 empty, `ptr`=1 → grant order 1,4,5,6,8,9,0,1. No `rd_en` ever asserts on 2, 3 or 7.
- SKIP_EMPTY=0, channel 3 empty for 5 cycles → `rd_en`=0 and `ptr`=3 held for 5 cycles. Channel 3 is read in the cycle `rdempty[3]` falls, then 4.
- `stop_rd` pulsed high for 3 cycles mid-stream → no `rd_en` during the pulse. One final `dout_vld` occurs in the first stall cycle, and the sequence resumes without skipping or repeating a channel.
- All `rdempty`=1 and `halt_to_fifo`=1 → `start_aga`=1 next cycle. Dropping `halt_to_fifo` gives `start_aga`=0 next cycle.
- `rst_syn` asserted during streaming with `ptr`=6 → same cycle `rd_en`=0. Next cycle `dout_vld`=0, `ptr`=0. With `rst` low asynchronously, all outputs are 0 immediately.
